// File: rtl/apb_arb_pkg.sv
// Shared state encoding, default widths and watchdog sizing for the APB
// write/read arbiter.
package apb_arb_pkg;

   localparam int unsigned RATIO_W_DEF = 3;
   localparam int unsigned CNT_W_DEF   = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_WR = 2'd1,
      GNT_RD = 2'd2
   } arb_state_t;

   // Counter width for a watchdog that must reach timeout_cycles-1; at least 1 bit.
   function automatic int unsigned wdog_w(input int unsigned timeout_cycles);
      if (timeout_cycles < 2) return 1;
      return int'($clog2(timeout_cycles));
   endfunction

endpackage

// File: rtl/apb_wr_rd_arbiter_xfer_watchdog.sv
// Grant watchdog: counts cycles a grant is held and flags the last allowed
// cycle so the arbiter can abort a stalled APB transfer.
module xfer_watchdog
   import apb_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire_c
);

   localparam int unsigned WDOG_W = wdog_w(TIMEOUT_CYCLES);

   logic [WDOG_W-1:0] wdog;

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_off
         assign wdog     = '0;
         assign expire_c = 1'b0;
      end else begin : g_on
         localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               wdog <= '0;
            end else if (clr) begin
               wdog <= '0;
            end else if (en) begin
               wdog <= wdog + WDOG_W'(1);
            end
         end

         assign expire_c = en && (wdog == LAST);
      end
   endgenerate

endmodule

// File: rtl/apb_wr_rd_arbiter.sv
// Arbitrates the single APB master port between the pending-write and
// pending-read paths, weighting writes by wr_rd_ratio.
module apb_wr_rd_arbiter
   import apb_arb_pkg::*;
#(
   parameter int unsigned RATIO_W        = RATIO_W_DEF,
   parameter int unsigned CNT_W          = CNT_W_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_req,
   input  logic               rd_req,
   input  logic [RATIO_W-1:0] wr_rd_ratio,
   input  logic               xfer_done,
   output logic               wr_grant,
   output logic               rd_grant,
   output logic               busy,
   output logic               timeout_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1 << RATIO_W);

   arb_state_t       state;
   arb_state_t       state_nxt;
   logic [CNT_W-1:0] wr_cnt;
   logic [CNT_W-1:0] wr_cnt_nxt;
   logic             timeout_nxt;
   logic             expire_c;
   logic             fin_c;
   logic             wdog_clr_c;
   logic             wdog_en_c;

   assign wdog_clr_c = (state == IDLE);
   assign wdog_en_c  = (state != IDLE);
   assign fin_c      = xfer_done || expire_c;

   xfer_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .clr      (wdog_clr_c),
      .en       (wdog_en_c),
      .expire_c (expire_c)
   );

   // Next-state, write-run counter and abort flag.
   always_comb begin
      state_nxt   = state;
      wr_cnt_nxt  = wr_cnt;
      timeout_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (wr_req && (!rd_req || (wr_cnt <= CNT_W'(wr_rd_ratio)))) begin
               state_nxt = GNT_WR;
            end else if (rd_req) begin
               state_nxt = GNT_RD;
            end
         end
         GNT_WR: begin
            if (fin_c) begin
               state_nxt   = IDLE;
               wr_cnt_nxt  = (wr_cnt >= CNT_MAX) ? CNT_MAX : wr_cnt + CNT_W'(1);
               timeout_nxt = !xfer_done;
            end
         end
         GNT_RD: begin
            if (fin_c) begin
               state_nxt   = IDLE;
               wr_cnt_nxt  = '0;
               timeout_nxt = !xfer_done;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Grants are decoded from the next state so they are flops aligned with state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         wr_cnt      <= '0;
         wr_grant    <= 1'b0;
         rd_grant    <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         wr_cnt      <= wr_cnt_nxt;
         wr_grant    <= (state_nxt == GNT_WR);
         rd_grant    <= (state_nxt == GNT_RD);
         busy        <= (state_nxt != IDLE);
         timeout_err <= timeout_nxt;
      end
   end

endmodule

// File: doc/apb_wr_rd_arbiter.md
Name: apb_wr_rd_arbiter

Overview:
- Shares the single APB4 master port of the AXI4-lite to APB4 bridge between the pending-write and pending-read paths.
- Weights write vs. read service using the 3-bit wr_rd_ratio field from the master config register.
- Issues one-hot grants, holds each grant until the APB transfer completes, and aborts a stalled transfer with a watchdog.

Parameters:
- RATIO_W, 3, width of wr_rd_ratio.
- CNT_W, 4, width of the consecutive-write counter; must hold 2^RATIO_W.
- TIMEOUT_CYCLES, 256, cycles a grant may wait for xfer_done before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_req  in  1  complete AXI write (AW+W) pending; held until granted.
- rd_req  in  1  AXI read (AR) pending; held until granted.
- wr_rd_ratio  in  RATIO_W  config: max consecutive writes = ratio+1 while a read waits.
- xfer_done  in  1  APB access phase completing (PSEL&PENABLE&PREADY), one-cycle pulse.
- wr_grant  out  1  APB port owned by the write path.
- rd_grant  out  1  APB port owned by the read path.
- busy  out  1  a grant is active.
- timeout_err  out  1  one-cycle pulse, transfer aborted by watchdog.

Behaviour:
- Reset: state IDLE; wr_grant=0, rd_grant=0, busy=0, timeout_err=0, wr_cnt=0, wdog=0. All outputs are registered.
- FSM states: IDLE, GNT_WR, GNT_RD. wr_grant=(state==GNT_WR), rd_grant=(state==GNT_RD), busy=!IDLE. The two grants are never both 1.
- IDLE decision, using this cycle's inputs; the grant appears on the next edge, giving 1-cycle latency:
  - wr_req only -> GNT_WR.
  - rd_req only -> GNT_RD.
  - Both requests and wr_cnt <= wr_rd_ratio -> GNT_WR.
  - Both requests and wr_cnt > wr_rd_ratio -> GNT_RD.
  - Neither -> stay in IDLE.
- wr_rd_ratio is sampled only in the IDLE decision cycle. Changing it mid-grant does not affect the current grant.
- Ratio semantics: with both paths saturated, ratio 0 alternates W,R,W,R; ratio 7 gives 8 W then 1 R.
- GNT_x: hold until xfer_done=1, then return to IDLE. There is always one IDLE cycle between grants, which aligns with the APB setup phase.
- wr_cnt updates on grant completion (xfer_done or timeout):
  - Write completion: wr_cnt+1, saturating at 2^RATIO_W.
  - Read completion: wr_cnt=0.
  - It also counts writes made while no read is pending. A read arriving after a long write run is therefore served at the next decision.
- Watchdog:
  - wdog clears on entering GNT_x and increments each cycle in GNT_x.
  - At wdog==TIMEOUT_CYCLES-1 with no xfer_done: go to IDLE and pulse timeout_err the next cycle. wr_cnt updates as for a completion.
  - xfer_done in the same cycle as expiry: done wins, no error.
  - TIMEOUT_CYCLES=0: the counter is held at 0 and never fires.
- xfer_done in IDLE is ignored; no state change.
- rst asserted mid-grant: grants drop asynchronously and immediately. The in-flight APB transfer is the bridge's responsibility.

Decomposition:
- Package apb_arb_pkg:
  - State enum arb_state_t {IDLE, GNT_WR, GNT_RD}.
  - RATIO_W and CNT_W defaults.
  - Watchdog width function clog2(TIMEOUT_CYCLES).
- Sub-module xfer_watchdog holds the counter, enable/clear, and expire output, parameterised by TIMEOUT_CYCLES. The FSM and wr_cnt stay in the top module.

Test Plan:
- Reset release with wr_req=1 -> wr_grant=1 exactly 1 cycle later. busy=1 until xfer_done. IDLE for 1 cycle after xfer_done.
- Ratio 0, both requests held for 6 transfers, xfer_done 2 cycles after each grant -> grant order W,R,W,R,W,R.
- Ratio 2, both held -> W,W,W,R,W,W,W,R. Ratio changed to 0 during the 2nd W grant -> current grant is unaffected, and the sequence continues with R next.
- 10 writes with rd_req=0 (wr_cnt saturates at 8), then rd_req asserted together with wr_req at ratio 7 -> next grant is R, and wr_cnt=0 after it completes.
- TIMEOUT_CYCLES=8, grant with no xfer_done -> grant drops after 8 cycles and timeout_err pulses for 1 cycle. A repeat with xfer_done on the 8th cycle -> no timeout_err.
- rst pulsed mid-GNT_RD -> rd_grant=0 within the same cycle, and wr_cnt=0. After release, a pending wr_req is granted 1 cycle later.
